// File: rtl/prim_pipe_pkg.sv
// Shared helpers for the elastic flop pipeline: counter width derivation and
// parameter sanity check.
package prim_pipe_pkg;

    function automatic int pipe_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit pipe_params_ok(input int width, input int depth);
        return (width >= 1) && (depth >= 1);
    endfunction

endpackage

// File: rtl/prim_flop_pipe_if.sv
// Handshake bundle for prim_flop_pipe; slave is the pipeline side, master the
// upstream/downstream environment.
interface prim_flop_pipe_if
    import prim_pipe_pkg::*;
#(
    parameter int Width = 32,
    parameter int Depth = 2,
    parameter int CntW  = pipe_cnt_w(Depth)
) ();
    logic             flush_i;
    logic             valid_i;
    logic             ready_o;
    logic [Width-1:0] data_i;
    logic             valid_o;
    logic             ready_i;
    logic [Width-1:0] data_o;
    logic [CntW-1:0]  count_o;

    modport master (
        output flush_i, valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, count_o
    );

    modport slave (
        input  flush_i, valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, count_o
    );
endinterface

// File: rtl/prim_flop_pipe_stage.sv
// One pipeline stage: a valid flop plus a data flop that only loads when a
// valid item actually moves in.
module prim_flop_pipe_stage #(
    parameter int               Width      = 32,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);
    logic             valid_reg;
    logic [Width-1:0] data_reg;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_reg <= 1'b0;
        end else if (clr_i) begin
            valid_reg <= 1'b0;
        end else if (en_i) begin
            valid_reg <= valid_i;
        end
    end

    // Data is kept across a flush; only the valid bit is dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_reg <= ResetValue;
        end else if (en_i && valid_i && !clr_i) begin
            data_reg <= data_i;
        end
    end

    assign valid_o = valid_reg;
    assign data_o  = data_reg;
endmodule

// File: rtl/prim_flop_pipe.sv
// Elastic Depth-stage register pipeline with bubble collapsing, flush and a
// registered occupancy count.
module prim_flop_pipe
    import prim_pipe_pkg::*;
#(
    parameter int               Width      = 32,
    parameter int               Depth      = 2,
    parameter logic [Width-1:0] ResetValue = '0,
    parameter int               CntW       = pipe_cnt_w(Depth)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    prim_flop_pipe_if.slave   bus
);
    if (!pipe_params_ok(Width, Depth)) begin : g_param_err
        $error("prim_flop_pipe: Width and Depth must both be >= 1");
    end

    logic [Depth:0]   rdy;
    logic [Depth-1:0] v;
    logic [Depth-1:0] v_next;
    logic [Depth-1:0] src_v;
    logic [Width-1:0] src_d [Depth];
    logic [Width-1:0] d     [Depth];
    logic [CntW-1:0]  count_reg;
    logic [CntW-1:0]  count_next;

    // Ready ripples back combinationally from the output; not broken internally.
    assign rdy[Depth] = bus.ready_i & ~bus.flush_i;

    generate
        for (genvar gi = 0; gi < Depth; gi++) begin : g_stage
            assign rdy[gi] = ~v[gi] | rdy[gi+1];

            if (gi == 0) begin : g_src_in
                assign src_v[gi] = bus.valid_i;
                assign src_d[gi] = bus.data_i;
            end else begin : g_src_prev
                assign src_v[gi] = v[gi-1];
                assign src_d[gi] = d[gi-1];
            end

            assign v_next[gi] = bus.flush_i ? 1'b0 : (rdy[gi] ? src_v[gi] : v[gi]);

            prim_flop_pipe_stage #(
                .Width      (Width),
                .ResetValue (ResetValue)
            ) u_stage (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .clr_i   (bus.flush_i),
                .en_i    (rdy[gi]),
                .valid_i (src_v[gi]),
                .data_i  (src_d[gi]),
                .valid_o (v[gi]),
                .data_o  (d[gi])
            );
        end
    endgenerate

    always_comb begin
        count_next = '0;
        for (int k = 0; k < Depth; k++) begin
            count_next = count_next + CntW'(v_next[k]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign bus.ready_o = rdy[0] & ~bus.flush_i;
    assign bus.valid_o = v[Depth-1] & ~bus.flush_i;
    assign bus.data_o  = d[Depth-1];
    assign bus.count_o = count_reg;
endmodule

// File: tb/tb_prim_flop_pipe.sv
// Directed scoreboard bench for prim_flop_pipe (Width 8, Depth 3, ResetValue A5).
module tb_prim_flop_pipe;
    logic clk;
    logic rst_n;

    prim_flop_pipe_if #(.Width(8), .Depth(3)) bus ();

    prim_flop_pipe #(
        .Width      (8),
        .Depth      (3),
        .ResetValue (8'hA5)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_out = 0;
    int first_acc_cyc = -1;
    int first_out_cyc = -1;
    int last_out_cyc = -1;
    int acc_mark;
    int out_mark;
    logic       s_ready, s_valid, s_acc, s_xfer;
    logic [7:0] s_data;
    logic [1:0] s_count;
    logic [7:0] q[$];
    logic [7:0] nxt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, sample mid-cycle, score transfers,
    // then retire at the rising edge.
    task automatic step(input logic vi, input logic [7:0] di, input logic ri,
                        input logic fl, input logic rn);
        logic [7:0] exp;
        @(negedge clk);
        bus.valid_i = vi;
        bus.data_i  = di;
        bus.ready_i = ri;
        bus.flush_i = fl;
        rst_n       = rn;
        #1;
        cyc++;
        s_ready = bus.ready_o;
        s_valid = bus.valid_o;
        s_data  = bus.data_o;
        s_count = bus.count_o;
        s_acc   = vi & s_ready & rn;
        s_xfer  = s_valid & ri & rn;
        if (s_xfer) begin
            n_out++;
            if (first_out_cyc < 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
            if (q.size() == 0) begin
                check("out_without_in", 32'(q.size()), 32'd1);
            end else begin
                exp = q.pop_front();
                check("out_data", {24'd0, s_data}, {24'd0, exp});
            end
        end
        if (s_acc) begin
            n_acc++;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            q.push_back(di);
        end
        @(posedge clk);
        if (!rn || fl) q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.valid_i = 1'b0;
        bus.data_i  = 8'h00;
        bus.ready_i = 1'b0;
        bus.flush_i = 1'b0;

        // Reset held two cycles with valid_i high.
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        check("rst_valid", 32'(s_valid), 32'd0);
        check("rst_data", 32'(s_data), 32'hA5);
        check("rst_count", 32'(s_count), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            check("post_rst_valid", 32'(s_valid), 32'd0);
            check("post_rst_count", 32'(s_count), 32'd0);
        end
        check("post_rst_no_out", 32'(n_out), 32'd0);

        // Streaming 0x01..0x10 with ready_i high.
        first_acc_cyc = -1;
        first_out_cyc = -1;
        out_mark = n_out;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i + 1), 1'b1, 1'b0, 1'b1);
            check("stream_ready", 32'(s_ready), 32'd1);
            if (i == 8) check("stream_count", 32'(s_count), 32'd3);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("stream_latency", 32'(first_out_cyc - first_acc_cyc), 32'd3);
        check("stream_outs", 32'(n_out - out_mark), 32'd16);
        check("stream_contig", 32'(last_out_cyc - first_out_cyc), 32'd15);
        check("stream_drained", 32'(q.size()), 32'd0);

        // Stall and fill: five offers under back-pressure.
        acc_mark = n_acc;
        nxt = 8'h21;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, nxt, 1'b0, 1'b0, 1'b1);
            if (s_acc) nxt++;
        end
        check("fill_accepts", 32'(n_acc - acc_mark), 32'd3);
        check("fill_ready", 32'(s_ready), 32'd0);
        check("fill_count", 32'(s_count), 32'd3);
        step(1'b1, nxt, 1'b1, 1'b0, 1'b1);
        check("full_release_ready", 32'(s_ready), 32'd1);
        check("full_release_acc", 32'(s_acc), 32'd1);
        check("full_release_xfer", 32'(s_xfer), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("full_inout_count", 32'(s_count), 32'd3);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("fill_drained", 32'(q.size()), 32'd0);
        check("fill_empty_valid", 32'(s_valid), 32'd0);

        // Bubble collapse: a single item walks to the output stage.
        step(1'b1, 8'h31, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            check("bubble_ready", 32'(s_ready), 32'd1);
        end
        check("bubble_at_out", 32'(s_valid), 32'd1);
        check("bubble_count1", 32'(s_count), 32'd1);
        step(1'b1, 8'h32, 1'b0, 1'b0, 1'b1);
        check("bubble_acc2", 32'(s_acc), 32'd1);
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
        check("bubble_acc3", 32'(s_acc), 32'd1);
        step(1'b1, 8'h34, 1'b0, 1'b0, 1'b1);
        check("bubble_full_ready", 32'(s_ready), 32'd0);
        check("bubble_full_count", 32'(s_count), 32'd3);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("bubble_drained", 32'(q.size()), 32'd0);

        // Flush with two items stored and both handshakes requested.
        step(1'b1, 8'h41, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h42, 1'b0, 1'b0, 1'b1);
        out_mark = n_out;
        step(1'b1, 8'h43, 1'b1, 1'b1, 1'b1);
        check("flush_pre_count", 32'(s_count), 32'd2);
        check("flush_ready", 32'(s_ready), 32'd0);
        check("flush_valid", 32'(s_valid), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("flush_count", 32'(s_count), 32'd0);
        check("flush_after_valid", 32'(s_valid), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("flush_no_out", 32'(n_out - out_mark), 32'd0);

        // Reset together with flush on a full pipe.
        step(1'b1, 8'h51, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h52, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h53, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h54, 1'b0, 1'b0, 1'b1);
        check("mid_full_count", 32'(s_count), 32'd3);
        step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("mid_rst_valid", 32'(s_valid), 32'd0);
        check("mid_rst_data", 32'(s_data), 32'hA5);
        check("mid_rst_count", 32'(s_count), 32'd0);
        check("mid_rst_ready", 32'(s_ready), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("final_queue", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prim_flop_pipe.md
# prim_flop_pipe

Parametrised elastic register pipeline: `Depth` stages of `Width`-bit registers with a per-stage valid bit, valid/ready handshake on both ports, bubble collapsing, synchronous flush and an occupancy count. It succeeds the single-stage reset-value flop primitive. Use it wherever a datapath needs N cycles of retiming, such as crossbar or bus-bridge timing cuts and core-to-peripheral paths. Unlike a plain flop chain, it holds data under back-pressure.

## Interface
Parameters:
- `Width`, default 32: data width in bits, ≥1.
- `Depth`, default 2: number of register stages, ≥1. `Depth == 0` is an elaboration error.
- `ResetValue`, default 0: `[Width-1:0]` value loaded into every data register on reset.
- `CntW`, default `$clog2(Depth+1)`: derived; width of `count_o`.

Ports:
- `clk_i`: in, 1, sole clock; all state updates on the rising edge.
- `rst_ni`: in, 1, reset; synchronous and active-low.
- `flush_i`: in, 1, synchronous flush; drops all stored items.
- `valid_i`: in, 1, upstream item valid.
- `ready_o`: out, 1, pipeline accepts an item this cycle.
- `data_i`: in, `Width`, upstream data.
- `valid_o`: out, 1, output stage holds an item.
- `ready_i`: in, 1, downstream accepts the item.
- `data_o`: out, `Width`, output-stage data.
- `count_o`: out, `CntW`, number of valid stages; registered.

## Operation
- Stage k holds `v[k]` and `d[k]`. Stage 0 is the input stage; stage `Depth-1` drives `valid_o` and `data_o`.
- Stage ready chain:
  - `rdy[Depth] = ready_i & ~flush_i`.
  - `rdy[k] = ~v[k] | rdy[k+1]`.
  - `ready_o = rdy[0] & ~flush_i`.
- The chain is combinational. No registered ready and no skid is required.
- Stage k loads on `rdy[k]`:
  - Stage 0: `v[0] <= valid_i`, `d[0] <= data_i`.
  - Stage k>0: `v[k] <= v[k-1]`, `d[k] <= d[k-1]`.
- Data registers are clock-enabled by `rdy[k] & src_valid`. Data does not toggle when no valid item arrives.
- Bubble collapsing: an empty stage accepts from behind even while the stages ahead are stalled. Up to `Depth` items are held under a full stall.
- Output handshake: a transfer occurs when `valid_o & ready_i & ~flush_i`.
- `valid_o = v[Depth-1] & ~flush_i`, so no output transfer completes in a flush cycle.
- Flush: on the next edge all `v[k] <= 0` and `count_o <= 0`. Data registers keep their values. No input is accepted in the flush cycle.
- `count_o` next value = popcount of the next `v` vector.
- Reset (`rst_ni` low at an edge):
  - All `v` = 0, all `d` = `ResetValue`, `count_o` = 0.
  - Reset overrides flush and any handshake in the same cycle.
  - Items in flight at reset are lost.

## Timing
- Latency from input transfer to `valid_o` is `Depth` cycles when `ready_i` stays high.
- Throughput: 1 item/cycle sustained. No bubbles are inserted when `ready_i` is constantly high.
- Outputs during reset and the first cycle after: `valid_o`=0, `data_o`=`ResetValue`, `ready_o`=1 (unless `flush_i`), `count_o`=0.
- Full (`count_o == Depth`, `ready_i`=0): `ready_o`=0.
- Full with `ready_i`=1: `ready_o`=1. A simultaneous in and out keeps `count_o` unchanged.
- Empty: `valid_o`=0, and `data_o` holds the last value.
- The combinational path `ready_i` → `ready_o` spans `Depth` AND/OR levels. The integrator constrains it. It is not broken internally.
- `count_o` reflects state after the edge. It is not a lookahead value.

## Structure
- Shared package `prim_pipe_pkg`:
  - Function `pipe_cnt_w(depth)` returning `$clog2(depth+1)`.
  - Parameter-check macro/assertion for `Depth ≥ 1`, `Width ≥ 1`.
- Sub-module `prim_flop_pipe_stage`:
  - One stage: valid flop plus enabled data flop.
  - Synchronous active-low reset to 0 / `ResetValue`.
  - Ports `clk_i`, `rst_ni`, `clr_i`, `en_i`, `valid_i`, `data_i`, `valid_o`, `data_o`.
  - The top instantiates `Depth` of these in a generate loop and owns the ready chain and counter.

## Test plan
- Reset: `Width`=8, `Depth`=3, `ResetValue`=8'hA5; hold `rst_ni`=0 for 2 cycles with `valid_i`=1 → `valid_o`=0, `data_o`=8'hA5, `count_o`=0, and no item emerges after release.
- Streaming: `ready_i`=1, inject 0x01..0x10 on consecutive cycles → `valid_o` rises exactly 3 cycles after the first accept. Outputs are 0x01..0x10 in order on 16 consecutive cycles, and `count_o` holds 3 mid-stream.
- Stall and fill: `ready_i`=0, offer 5 items → exactly 3 accepted, then `ready_o`=0 and `count_o`=3. Raise `ready_i` → 3 items emerge in order and the 4th is accepted the same cycle as the first output.
- Bubble collapse: load one item, hold `ready_i`=0 for 4 cycles → the item reaches stage 2 and `ready_o` stays 1 until `count_o`=3.
- Flush: `count_o`=2, assert `flush_i` with `valid_i`=1 and `ready_i`=1 → `ready_o`=0 and `valid_o`=0 that cycle, with no transfer on either port. Next cycle `count_o`=0 and `valid_o`=0.
- Reset mid-operation: full pipe with `flush_i`=1 and `rst_ni`=0 together → reset values everywhere next cycle, and `data_o`=`ResetValue`, not the stale data.
